regfile_wport_arbiter: RTL and testbench

//  Shares the single register-file write port between two requesters:
//   - the in-order pipeline WB stage, which has fixed priority and no back-pressure;
//   - the long-latency unit (divider/load miss), buffered through a FIFO.

---
 rtl/regfile_wport_arbiter_if.sv | 45 ++++
 rtl/regfile_wport_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_wport_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wport_arbiter_if.sv
// Signal bundle between the write-port arbiter and its neighbours: WB stage,
// long-latency unit, decode interlock and the register-file write port.
interface regfile_wport_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              pipe_we;
  logic [4:0]        pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;

  logic              aux_valid;
  logic              aux_ready;
  logic [4:0]        aux_waddr;
  logic [DATA_W-1:0] aux_wdata;

  logic              aux_issue;
  logic [4:0]        aux_issue_addr;

  logic [4:0]        chk_src1;
  logic [4:0]        chk_src2;
  logic [4:0]        chk_dst;
  logic              stall_o;
  logic              pipe_hold_o;

  logic              wreg_en;
  logic [4:0]        wreg_addr;
  logic [DATA_W-1:0] wreg_data;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output aux_valid, aux_waddr, aux_wdata,
    output aux_issue, aux_issue_addr,
    output chk_src1, chk_src2, chk_dst,
    input  aux_ready, stall_o, pipe_hold_o,
    input  wreg_en, wreg_addr, wreg_data
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  aux_valid, aux_waddr, aux_wdata,
    input  aux_issue, aux_issue_addr,
    input  chk_src1, chk_src2, chk_dst,
    output aux_ready, stall_o, pipe_hold_o,
    output wreg_en, wreg_addr, wreg_data
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter: WB stage has fixed priority, long-latency
// results wait in a small FIFO; a pending scoreboard drives the decode stall.
module regfile_wport_arbiter #(
  parameter int AUX_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_wport_arbiter_if.slave  bus
);

  localparam int PTR_W    = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1;
  localparam int CNT_W    = $clog2(AUX_DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } aux_entry_t;

  aux_entry_t         fifo_mem [AUX_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_next;
  logic [CNT_W-1:0]   fifo_cnt, fifo_cnt_next;

  logic [31:0]        pending, pending_next;
  logic [STARVE_W-1:0] starve_cnt, starve_cnt_next;
  logic               hold_q, hold_next;

  logic               wreg_en_q, wreg_en_next;
  logic [4:0]         wreg_addr_q, wreg_addr_next;
  logic [DATA_W-1:0]  wreg_data_q, wreg_data_next;

  logic               fifo_empty;
  logic               fifo_full;
  logic               slot_free;
  logic               do_push;
  logic               do_pop;
  aux_entry_t         head;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CNT_W'(AUX_DEPTH));
  assign head       = fifo_mem[rd_ptr];

  // A WB write to r0 never reaches the regfile, so it leaves the slot usable.
  assign slot_free  = !bus.pipe_we || (bus.pipe_waddr == 5'd0);
  assign do_pop     = slot_free && !fifo_empty;
  assign do_push    = bus.aux_valid && !fifo_full && (bus.aux_waddr != 5'd0);

  assign bus.aux_ready   = !fifo_full;
  assign bus.pipe_hold_o = hold_q;
  assign bus.wreg_en     = wreg_en_q;
  assign bus.wreg_addr   = wreg_addr_q;
  assign bus.wreg_data   = wreg_data_q;

  assign bus.stall_o = ((bus.chk_src1 != 5'd0) && pending[bus.chk_src1]) ||
                       ((bus.chk_src2 != 5'd0) && pending[bus.chk_src2]) ||
                       ((bus.chk_dst  != 5'd0) && pending[bus.chk_dst]);

  // Write-port source selection.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    wreg_en_next   = 1'b0;
    wreg_addr_next = wreg_addr_q;
    wreg_data_next = wreg_data_q;
    if (!slot_free) begin
      wreg_en_next   = 1'b1;
      wreg_addr_next = bus.pipe_waddr;
      wreg_data_next = bus.pipe_wdata;
    end else if (!fifo_empty) begin
      wreg_en_next   = 1'b1;
      wreg_addr_next = head.addr;
      wreg_data_next = head.data;
    end
  end

  // FIFO pointers and occupancy.
  always_comb begin
    rd_ptr_next   = rd_ptr;
    wr_ptr_next   = wr_ptr;
    fifo_cnt_next = fifo_cnt;
    if (do_pop)  rd_ptr_next = rd_ptr + PTR_W'(1);
    if (do_push) wr_ptr_next = wr_ptr + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   fifo_cnt_next = fifo_cnt + CNT_W'(1);
      2'b01:   fifo_cnt_next = fifo_cnt - CNT_W'(1);
      default: fifo_cnt_next = fifo_cnt;
    endcase
  end

  // Scoreboard: the clear is applied before the set so a same-edge issue wins.
  always_comb begin
    pending_next = pending;
    if (do_pop) pending_next[head.addr] = 1'b0;
    if (bus.aux_issue && (bus.aux_issue_addr != 5'd0))
      pending_next[bus.aux_issue_addr] = 1'b1;
  end

  // Starvation: count blocked cycles with work queued; hold is sticky until a pop.
  always_comb begin
    starve_cnt_next = starve_cnt;
    hold_next       = hold_q;
    if (do_pop) begin
      starve_cnt_next = '0;
      hold_next       = 1'b0;
    end else if (!fifo_empty) begin
      if (starve_cnt < STARVE_W'(STARVE_LIMIT))
        starve_cnt_next = starve_cnt + STARVE_W'(1);
      if (starve_cnt_next >= STARVE_W'(STARVE_LIMIT))
        hold_next = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_cnt    <= '0;
      pending     <= '0;
      starve_cnt  <= '0;
      hold_q      <= 1'b0;
      wreg_en_q   <= 1'b0;
      wreg_addr_q <= '0;
      wreg_data_q <= '0;
    end else begin
      rd_ptr      <= rd_ptr_next;
      wr_ptr      <= wr_ptr_next;
      fifo_cnt    <= fifo_cnt_next;
      pending     <= pending_next;
      starve_cnt  <= starve_cnt_next;
      hold_q      <= hold_next;
      wreg_en_q   <= wreg_en_next;
      wreg_addr_q <= wreg_addr_next;
      wreg_data_q <= wreg_data_next;
    end
  end

  // NOTE: the entry storage has no reset; resetting the pointers and count
  // already makes every stale entry unreachable.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= '{addr: bus.aux_waddr, data: bus.aux_wdata};
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for regfile_wport_arbiter: directed scenarios plus a
// randomized run compared every cycle against a queue-based reference model.
module tb_regfile_wport_arbiter;

  localparam int AUX_DEPTH    = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int DATA_W       = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wport_arbiter_if #(.DATA_W(DATA_W)) bus ();

  regfile_wport_arbiter #(
    .AUX_DEPTH   (AUX_DEPTH),
    .STARVE_LIMIT(STARVE_LIMIT),
    .DATA_W      (DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [4:0]        addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t        m_q[$];
  bit   [31:0] m_pend  = '0;
  int          m_starve = 0;
  bit          m_hold  = 1'b0;
  bit          m_en    = 1'b0;
  logic [4:0]  m_addr  = '0;
  logic [31:0] m_data  = '0;

  task automatic model_reset();
    m_q.delete();
    m_pend   = '0;
    m_starve = 0;
    m_hold   = 1'b0;
    m_en     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  task automatic model_step();
    bit   blocked;
    bit   popped;
    int   occ;
    ent_t e;
    blocked = bus.pipe_we && (bus.pipe_waddr != 5'd0);
    occ     = m_q.size();
    popped  = 1'b0;
    if (blocked) begin
      m_en = 1'b1; m_addr = bus.pipe_waddr; m_data = bus.pipe_wdata;
    end else if (occ > 0) begin
      e = m_q.pop_front();
      m_en = 1'b1; m_addr = e.addr; m_data = e.data;
      m_pend[e.addr] = 1'b0;
      popped = 1'b1;
    end else begin
      m_en = 1'b0;
    end
    if (bus.aux_valid && (occ < AUX_DEPTH) && (bus.aux_waddr != 5'd0))
      m_q.push_back({bus.aux_waddr, bus.aux_wdata});
    if (bus.aux_issue && (bus.aux_issue_addr != 5'd0))
      m_pend[bus.aux_issue_addr] = 1'b1;
    if (popped) begin
      m_starve = 0;
      m_hold   = 1'b0;
    end else if (occ > 0) begin
      m_starve++;
      if (m_starve >= STARVE_LIMIT) m_hold = 1'b1;
    end
  endtask

  function automatic bit pend_hit(logic [4:0] a);
    return (a != 5'd0) && m_pend[a];
  endfunction

  // Advance one clock: model follows the DUT edge, then settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_step();
    #1;
  endtask

  task automatic idle_inputs();
    bus.pipe_we = 1'b0;  bus.pipe_waddr = '0; bus.pipe_wdata = '0;
    bus.aux_valid = 1'b0; bus.aux_waddr = '0; bus.aux_wdata = '0;
    bus.aux_issue = 1'b0; bus.aux_issue_addr = '0;
    bus.chk_src1 = '0; bus.chk_src2 = '0; bus.chk_dst = '0;
  endtask

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("wreg_en", bus.wreg_en, m_en);
        if (m_en) begin
          check("wreg_addr", bus.wreg_addr, m_addr);
          check("wreg_data", bus.wreg_data, m_data);
        end
        check("aux_ready", bus.aux_ready, m_q.size() < AUX_DEPTH);
        check("stall_o", bus.stall_o,
              pend_hit(bus.chk_src1) || pend_hit(bus.chk_src2) || pend_hit(bus.chk_dst));
        check("pipe_hold_o", bus.pipe_hold_o, m_hold);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] a;
    idle_inputs();
    model_reset();
    repeat (3) tick();
    check("rst_wreg_en",   bus.wreg_en,   32'd0);
    check("rst_wreg_addr", bus.wreg_addr, 32'd0);
    check("rst_wreg_data", bus.wreg_data, 32'd0);
    check("rst_aux_ready", bus.aux_ready, 32'd1);

    // 1: reset release
    rst = 1'b1;
    cmp_en = 1'b1;
    tick();
    check("t1_wreg_en",  bus.wreg_en,     32'd0);
    check("t1_ready",    bus.aux_ready,   32'd1);
    check("t1_stall",    bus.stall_o,     32'd0);
    check("t1_hold",     bus.pipe_hold_o, 32'd0);

    // 2: pipe write, then r0 write
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd5; bus.pipe_wdata = 32'hDEAD;
    tick();
    check("t2_en",   bus.wreg_en,   32'd1);
    check("t2_addr", bus.wreg_addr, 32'd5);
    check("t2_data", bus.wreg_data, 32'hDEAD);
    bus.pipe_waddr = 5'd0;
    tick();
    check("t2_r0_en", bus.wreg_en, 32'd0);
    bus.pipe_we = 1'b0;

    // 3: issue r7, stall, result drains two cycles after presentation
    bus.aux_issue = 1'b1; bus.aux_issue_addr = 5'd7;
    tick();
    bus.aux_issue = 1'b0;
    bus.chk_src1 = 5'd7;
    #1;
    check("t3_stall_set", bus.stall_o, 32'd1);
    bus.aux_valid = 1'b1; bus.aux_waddr = 5'd7; bus.aux_wdata = 32'h1234;
    tick();
    bus.aux_valid = 1'b0;
    check("t3_no_bypass", bus.wreg_en, 32'd0);
    check("t3_stall_hold", bus.stall_o, 32'd1);
    tick();
    check("t3_en",    bus.wreg_en,   32'd1);
    check("t3_addr",  bus.wreg_addr, 32'd7);
    check("t3_data",  bus.wreg_data, 32'h1234);
    check("t3_stall", bus.stall_o,   32'd0);
    bus.chk_src1 = 5'd0;

    // 4: starvation under continuous WB writes
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd1; bus.pipe_wdata = 32'h11;
    bus.aux_valid = 1'b1; bus.aux_waddr = 5'd10; bus.aux_wdata = 32'hA0;
    tick();
    bus.aux_waddr = 5'd11; bus.aux_wdata = 32'hB0;
    tick();
    bus.aux_valid = 1'b0;
    check("t4_full",  bus.aux_ready,   32'd0);
    check("t4_hold1", bus.pipe_hold_o, 32'd0);
    tick();
    tick();
    check("t4_hold3", bus.pipe_hold_o, 32'd0);
    tick();
    check("t4_hold4",    bus.pipe_hold_o, 32'd1);
    check("t4_pipe_win", bus.wreg_addr,   32'd1);
    bus.pipe_we = 1'b0;
    tick();
    check("t4_head_addr", bus.wreg_addr,   32'd10);
    check("t4_head_data", bus.wreg_data,   32'hA0);
    check("t4_hold_drop", bus.pipe_hold_o, 32'd0);
    check("t4_ready",     bus.aux_ready,   32'd1);
    tick();
    check("t4_second", bus.wreg_addr, 32'd11);
    tick();
    check("t4_idle", bus.wreg_en, 32'd0);

    // 5: re-issue of r3 on the edge its older result drains
    bus.aux_issue = 1'b1; bus.aux_issue_addr = 5'd3;
    tick();
    bus.aux_issue = 1'b0;
    bus.aux_valid = 1'b1; bus.aux_waddr = 5'd3; bus.aux_wdata = 32'h33;
    tick();
    bus.aux_valid = 1'b0;
    bus.aux_issue = 1'b1; bus.aux_issue_addr = 5'd3;
    tick();
    bus.aux_issue = 1'b0;
    bus.chk_src1 = 5'd3;
    #1;
    check("t5_addr",  bus.wreg_addr, 32'd3);
    check("t5_stall", bus.stall_o,   32'd1);
    bus.aux_valid = 1'b1; bus.aux_waddr = 5'd3; bus.aux_wdata = 32'h34;
    tick();
    bus.aux_valid = 1'b0;
    tick();
    check("t5_cleared", bus.stall_o, 32'd0);
    bus.chk_src1 = 5'd0;

    // 6: reset with entries queued and r9 pending
    bus.aux_issue = 1'b1; bus.aux_issue_addr = 5'd9;
    tick();
    bus.aux_issue = 1'b0;
    bus.pipe_we = 1'b1; bus.pipe_waddr = 5'd2; bus.pipe_wdata = 32'h22;
    bus.aux_valid = 1'b1; bus.aux_waddr = 5'd12; bus.aux_wdata = 32'hC0;
    tick();
    bus.aux_waddr = 5'd13; bus.aux_wdata = 32'hD0;
    tick();
    bus.aux_valid = 1'b0;
    bus.chk_src1 = 5'd9;
    #1;
    check("t6_pre_full",  bus.aux_ready, 32'd0);
    check("t6_pre_stall", bus.stall_o,   32'd1);
    rst = 1'b0;
    model_reset();
    #1;
    check("t6_ready", bus.aux_ready, 32'd1);
    check("t6_stall", bus.stall_o,   32'd0);
    check("t6_en",    bus.wreg_en,   32'd0);
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.pipe_we    = ($urandom_range(0, 99) < (m_hold ? 10 : 60));
      bus.pipe_waddr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.pipe_wdata = $urandom;
      bus.aux_valid  = ($urandom_range(0, 99) < 40);
      bus.aux_waddr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.aux_wdata  = $urandom;
      a = 5'($urandom_range(1, 31));
      bus.aux_issue      = ($urandom_range(0, 99) < 25) && !m_pend[a];
      bus.aux_issue_addr = a;
      bus.chk_src1 = 5'($urandom_range(0, 31));
      bus.chk_src2 = 5'($urandom_range(0, 31));
      bus.chk_dst  = 5'($urandom_range(0, 31));
      if (cyc == 1500) begin
        rst = 1'b0;
        model_reset();
      end else if (cyc == 1503) begin
        rst = 1'b1;
      end
      tick();
    end

    idle_inputs();
    repeat (4) tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
